// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the coin-return path: denomination count, amount
// width, coin values, timing constants and the payout FSM state encoding.
package change_dispenser_pkg;

  localparam int kNumCoins   = 3;
  localparam int kTotalBits  = 31;
  localparam int kCoinVal0   = 100;
  localparam int kCoinVal1   = 500;
  localparam int kCoinVal2   = 1000;
  localparam int kInvBits    = 8;
  localparam int kInvInit    = 10;
  localparam int kAckTimeout = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_REQ    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Controller/hopper-facing signal bundle of the change dispenser. The
// dispenser sits on the slave side; the controller and hopper model drive
// the master side.
interface change_dispenser_if
  import change_dispenser_pkg::*;
#(
  parameter int NUM_COINS  = kNumCoins,
  parameter int TOTAL_BITS = kTotalBits
);

  logic                  i_start;
  logic [TOTAL_BITS-1:0] i_amount;
  logic [NUM_COINS-1:0]  i_refill;
  logic                  i_coin_ack;
  logic                  o_busy;
  logic [NUM_COINS-1:0]  o_coin_req;
  logic                  o_done;
  logic [TOTAL_BITS-1:0] o_remainder;
  logic                  o_fault;
  logic [NUM_COINS-1:0]  o_empty;

  modport slave (
    input  i_start, i_amount, i_refill, i_coin_ack,
    output o_busy, o_coin_req, o_done, o_remainder, o_fault, o_empty
  );

  modport master (
    output i_start, i_amount, i_refill, i_coin_ack,
    input  o_busy, o_coin_req, o_done, o_remainder, o_fault, o_empty
  );

endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// Per-denomination hopper stock: one saturating up/down counter per coin.
// A refill and a dispense of the same coin in one cycle cancel out.
module change_dispenser_coin_inventory
  import change_dispenser_pkg::*;
#(
  parameter int NUM_COINS = kNumCoins,
  parameter int INV_BITS  = kInvBits,
  parameter int INV_INIT  = kInvInit
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_COINS-1:0]                refill,
  input  logic [NUM_COINS-1:0]                dispense,
  output wire  [NUM_COINS-1:0][INV_BITS-1:0]  count,
  output wire  [NUM_COINS-1:0]                empty
);

  localparam logic [INV_BITS-1:0] INV_MAX      = {INV_BITS{1'b1}};
  localparam logic [INV_BITS-1:0] INV_INIT_VAL = INV_BITS'(INV_INIT);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COINS; gi++) begin : g_coin
      logic [INV_BITS-1:0] count_reg;
      logic [INV_BITS-1:0] count_next;
      logic                empty_reg;

      // Next count: +1 on refill (saturating), -1 on dispense (never below 0)
      always_comb begin
        count_next = count_reg;
        if (refill[gi] && !dispense[gi]) begin
          if (count_reg != INV_MAX) count_next = count_reg + 1'b1;
        end else if (dispense[gi] && !refill[gi]) begin
          if (count_reg != '0) count_next = count_reg - 1'b1;
        end
      end

      // Counter and registered empty flag
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          count_reg <= INV_INIT_VAL;
          empty_reg <= (INV_INIT_VAL == '0);
        end else begin
          count_reg <= count_next;
          empty_reg <= (count_next == '0);
        end
      end

      assign count[gi] = count_reg;
      assign empty[gi] = empty_reg;
    end
  endgenerate

endmodule

// File: rtl/change_dispenser.sv
// Coin-return payout engine. Takes a change amount and ejects it one coin at
// a time through a req/ack handshake, always choosing the largest coin that
// still fits and is in stock. Reports the unpaid remainder and ack timeouts.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int NUM_COINS   = kNumCoins,
  parameter int TOTAL_BITS  = kTotalBits,
  parameter int COIN_VAL0   = kCoinVal0,
  parameter int COIN_VAL1   = kCoinVal1,
  parameter int COIN_VAL2   = kCoinVal2,
  parameter int INV_BITS    = kInvBits,
  parameter int INV_INIT    = kInvInit,
  parameter int ACK_TIMEOUT = kAckTimeout
) (
  input logic               clk,
  input logic               reset_n,
  change_dispenser_if.slave bus
);

  localparam int TIMER_BITS = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(ACK_TIMEOUT - 1);
  localparam logic [TOTAL_BITS-1:0] COIN_VAL [NUM_COINS] = '{
    TOTAL_BITS'(COIN_VAL0), TOTAL_BITS'(COIN_VAL1), TOTAL_BITS'(COIN_VAL2)
  };

  state_t                              state_reg;
  logic                                busy_reg;
  logic [NUM_COINS-1:0]                coin_req_reg;
  logic                                done_reg;
  logic [TOTAL_BITS-1:0]               remainder_reg;
  logic                                fault_reg;
  logic [TOTAL_BITS-1:0]               remaining_reg;
  logic [TOTAL_BITS-1:0]               cur_val_reg;
  logic [TIMER_BITS-1:0]               timer_reg;

  logic                                sel_found;
  logic [NUM_COINS-1:0]                sel_onehot;
  logic [TOTAL_BITS-1:0]               sel_val;
  logic [NUM_COINS-1:0]                dispense;
  logic [NUM_COINS-1:0]                fits;
  wire  [NUM_COINS-1:0][INV_BITS-1:0]  inv_count;
  wire  [NUM_COINS-1:0]                inv_empty;

  // A coin is a candidate when it does not overshoot the balance and is in stock
  genvar gi;
  generate
    for (gi = 0; gi < NUM_COINS; gi++) begin : g_fit
      assign fits[gi] = (COIN_VAL[gi] <= remaining_reg) && (inv_count[gi] != '0);
    end
  endgenerate

  // Largest-denomination-first pick: the highest candidate index wins
  always_comb begin
    sel_found  = 1'b0;
    sel_onehot = '0;
    sel_val    = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (fits[i]) begin
        sel_found  = 1'b1;
        sel_onehot = NUM_COINS'(1) << i;
        sel_val    = COIN_VAL[i];
      end
    end
  end

  // Inventory is only debited for a coin the hopper actually acknowledged
  assign dispense = (state_reg == S_REQ && bus.i_coin_ack) ? coin_req_reg : '0;

  change_dispenser_coin_inventory #(
    .NUM_COINS (NUM_COINS),
    .INV_BITS  (INV_BITS),
    .INV_INIT  (INV_INIT)
  ) u_inv (
    .clk      (clk),
    .reset_n  (reset_n),
    .refill   (bus.i_refill),
    .dispense (dispense),
    .count    (inv_count),
    .empty    (inv_empty)
  );

  // Payout FSM with registered outputs; o_done is a single-cycle pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      busy_reg      <= 1'b0;
      coin_req_reg  <= '0;
      done_reg      <= 1'b0;
      remainder_reg <= '0;
      fault_reg     <= 1'b0;
      remaining_reg <= '0;
      cur_val_reg   <= '0;
      timer_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.i_start) begin
            remaining_reg <= bus.i_amount;
            fault_reg     <= 1'b0;
            remainder_reg <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            coin_req_reg <= sel_onehot;
            cur_val_reg  <= sel_val;
            timer_reg    <= '0;
            state_reg    <= S_REQ;
          end else begin
            done_reg      <= 1'b1;
            remainder_reg <= remaining_reg;
            state_reg     <= S_DONE;
          end
        end
        S_REQ: begin
          if (bus.i_coin_ack) begin
            remaining_reg <= remaining_reg - cur_val_reg;
            coin_req_reg  <= '0;
            state_reg     <= S_SELECT;
          end else if (timer_reg == TIMER_LAST) begin
            fault_reg     <= 1'b1;
            coin_req_reg  <= '0;
            done_reg      <= 1'b1;
            remainder_reg <= remaining_reg;
            state_reg     <= S_DONE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg     <= 1'b0;
          coin_req_reg <= '0;
          state_reg    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy      = busy_reg;
  assign bus.o_coin_req  = coin_req_reg;
  assign bus.o_done      = done_reg;
  assign bus.o_remainder = remainder_reg;
  assign bus.o_fault     = fault_reg;
  assign bus.o_empty     = inv_empty;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser: payout ordering,
// remainder, timeout fault, reset in mid-request and inventory refill.
module tb_change_dispenser;
  import change_dispenser_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  change_dispenser_if bus_if ();

  change_dispenser dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0]  req_log [$];
  int          first_req_cyc;
  int          done_cyc;
  logic [30:0] done_rem;
  logic        done_fault;

  // Start a payout and play the hopper; iteration i observes outputs after edge N+i
  task automatic run_payout(input logic [30:0] amt, input bit ack_en, input int limit);
    req_log.delete();
    first_req_cyc = -1;
    done_cyc      = -1;
    done_rem      = '0;
    done_fault    = 1'b0;
    @(negedge clk);
    bus_if.i_start  = 1'b1;
    bus_if.i_amount = amt;
    @(negedge clk);
    bus_if.i_start  = 1'b0;
    for (int i = 0; i < limit; i++) begin
      bus_if.i_coin_ack = 1'b0;
      if (bus_if.o_coin_req != '0 && first_req_cyc < 0) first_req_cyc = i;
      if (bus_if.o_coin_req != '0 && (ack_en || req_log.size() == 0)) begin
        req_log.push_back(bus_if.o_coin_req);
        if (ack_en) bus_if.i_coin_ack = 1'b1;
      end
      if (bus_if.o_done) begin
        done_cyc   = i;
        done_rem   = bus_if.o_remainder;
        done_fault = bus_if.o_fault;
        break;
      end
      @(negedge clk);
    end
    bus_if.i_coin_ack = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL payout_bound amount=%0d: o_done not seen within %0d cycles", amt, limit);
    end
    $display("payout amount=%0d reqs=%0d first_req=%0d done_at=%0d rem=%0d fault=%0b",
             amt, req_log.size(), first_req_cyc, done_cyc, done_rem, done_fault);
  endtask

  task automatic test_reset();
    int exp_inv [3] = '{10, 10, 10};
    reset_n = 1'b0;
    bus_if.i_start = 1'b0; bus_if.i_amount = '0; bus_if.i_refill = '0; bus_if.i_coin_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_if.o_busy); end
    checks++; if (bus_if.o_coin_req !== 3'b000) begin errors++; $display("FAIL reset_req got=%b exp=000", bus_if.o_coin_req); end
    checks++; if (bus_if.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus_if.o_done); end
    checks++; if (bus_if.o_remainder !== 31'd0) begin errors++; $display("FAIL reset_rem got=%0d exp=0", bus_if.o_remainder); end
    checks++; if (bus_if.o_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus_if.o_fault); end
    checks++; if (bus_if.o_empty !== 3'b000) begin errors++; $display("FAIL reset_empty got=%b exp=000", bus_if.o_empty); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dut.inv_count[c] !== 8'(exp_inv[c])) begin
        errors++; $display("FAIL reset_inv%0d got=%0d exp=%0d", c, dut.inv_count[c], exp_inv[c]);
      end
    end
    reset_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_largest_first();
    logic [2:0] exp_req [3] = '{3'b100, 3'b010, 3'b001};
    run_payout(31'd1600, 1'b1, 100);
    checks++; if (req_log.size() != 3) begin errors++; $display("FAIL t1_req_count got=%0d exp=3", req_log.size()); end
    for (int k = 0; k < 3; k++) begin
      if (k < req_log.size()) begin
        checks++;
        if (req_log[k] !== exp_req[k]) begin errors++; $display("FAIL t1_req%0d got=%b exp=%b", k, req_log[k], exp_req[k]); end
      end
    end
    checks++; if (first_req_cyc != 1) begin errors++; $display("FAIL t1_latency got=%0d exp=1", first_req_cyc); end
    checks++; if (done_rem !== 31'd0) begin errors++; $display("FAIL t1_rem got=%0d exp=0", done_rem); end
    checks++; if (done_fault !== 1'b0) begin errors++; $display("FAIL t1_fault got=%b exp=0", done_fault); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dut.inv_count[c] !== 8'd9) begin errors++; $display("FAIL t1_inv%0d got=%0d exp=9", c, dut.inv_count[c]); end
    end
    @(negedge clk);
    checks++; if (bus_if.o_done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got=%b exp=0", bus_if.o_done); end
    checks++; if (bus_if.o_busy !== 1'b0) begin errors++; $display("FAIL t1_busy_after got=%b exp=0", bus_if.o_busy); end
  endtask

  task automatic test_zero_amount();
    run_payout(31'd0, 1'b1, 20);
    checks++; if (req_log.size() != 0) begin errors++; $display("FAIL t2_req_count got=%0d exp=0", req_log.size()); end
    checks++; if (done_cyc != 1) begin errors++; $display("FAIL t2_done_latency got=%0d exp=1", done_cyc); end
    checks++; if (done_rem !== 31'd0) begin errors++; $display("FAIL t2_rem got=%0d exp=0", done_rem); end
  endtask

  task automatic test_no_big_coin();
    int exp_inv [3] = '{9, 5, 0};
    run_payout(31'd9000, 1'b1, 200);
    checks++; if (req_log.size() != 9) begin errors++; $display("FAIL t3_drain_count got=%0d exp=9", req_log.size()); end
    checks++; if (bus_if.o_empty !== 3'b100) begin errors++; $display("FAIL t3_empty got=%b exp=100", bus_if.o_empty); end
    run_payout(31'd2000, 1'b1, 200);
    checks++; if (req_log.size() != 4) begin errors++; $display("FAIL t3_req_count got=%0d exp=4", req_log.size()); end
    for (int k = 0; k < req_log.size(); k++) begin
      checks++;
      if (req_log[k] !== 3'b010) begin errors++; $display("FAIL t3_req%0d got=%b exp=010", k, req_log[k]); end
    end
    checks++; if (done_rem !== 31'd0) begin errors++; $display("FAIL t3_rem got=%0d exp=0", done_rem); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dut.inv_count[c] !== 8'(exp_inv[c])) begin
        errors++; $display("FAIL t3_inv%0d got=%0d exp=%0d", c, dut.inv_count[c], exp_inv[c]);
      end
    end
  endtask

  task automatic test_remainder();
    run_payout(31'd150, 1'b1, 50);
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL t4_req_count got=%0d exp=1", req_log.size()); end
    if (req_log.size() > 0) begin
      checks++; if (req_log[0] !== 3'b001) begin errors++; $display("FAIL t4_req got=%b exp=001", req_log[0]); end
    end
    checks++; if (done_rem !== 31'd50) begin errors++; $display("FAIL t4_rem got=%0d exp=50", done_rem); end
    checks++; if (dut.inv_count[0] !== 8'd8) begin errors++; $display("FAIL t4_inv0 got=%0d exp=8", dut.inv_count[0]); end
  endtask

  task automatic test_timeout();
    run_payout(31'd500, 1'b0, 40);
    if (req_log.size() > 0) begin
      checks++; if (req_log[0] !== 3'b010) begin errors++; $display("FAIL t5_req got=%b exp=010", req_log[0]); end
    end
    checks++; if (done_cyc != 17) begin errors++; $display("FAIL t5_done_at got=%0d exp=17", done_cyc); end
    checks++; if (done_fault !== 1'b1) begin errors++; $display("FAIL t5_fault got=%b exp=1", done_fault); end
    checks++; if (done_rem !== 31'd500) begin errors++; $display("FAIL t5_rem got=%0d exp=500", done_rem); end
    checks++; if (dut.inv_count[1] !== 8'd5) begin errors++; $display("FAIL t5_inv1 got=%0d exp=5", dut.inv_count[1]); end
    // Stray ack while idle must not touch inventory; outputs stay held
    @(negedge clk); bus_if.i_coin_ack = 1'b1;
    @(negedge clk); bus_if.i_coin_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dut.inv_count[1] !== 8'd5) begin errors++; $display("FAIL t5_idle_ack_inv1 got=%0d exp=5", dut.inv_count[1]); end
    checks++; if (bus_if.o_remainder !== 31'd500) begin errors++; $display("FAIL t5_rem_held got=%0d exp=500", bus_if.o_remainder); end
    checks++; if (bus_if.o_fault !== 1'b1) begin errors++; $display("FAIL t5_fault_held got=%b exp=1", bus_if.o_fault); end
  endtask

  task automatic test_reset_mid_req();
    bit seen = 1'b0;
    @(negedge clk); bus_if.i_start = 1'b1; bus_if.i_amount = 31'd500;
    @(negedge clk); bus_if.i_start = 1'b0;
    checks++; if (bus_if.o_fault !== 1'b0) begin errors++; $display("FAIL t6_fault_clear got=%b exp=0", bus_if.o_fault); end
    checks++; if (bus_if.o_remainder !== 31'd0) begin errors++; $display("FAIL t6_rem_clear got=%0d exp=0", bus_if.o_remainder); end
    for (int i = 0; i < 10; i++) begin
      if (bus_if.o_coin_req != '0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (bus_if.o_coin_req !== 3'b010) begin errors++; $display("FAIL t6_req got=%b exp=010 seen=%0b", bus_if.o_coin_req, seen); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (bus_if.o_coin_req !== 3'b000) begin errors++; $display("FAIL t6_req_drop got=%b exp=000", bus_if.o_coin_req); end
    checks++; if (bus_if.o_busy !== 1'b0) begin errors++; $display("FAIL t6_busy got=%b exp=0", bus_if.o_busy); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dut.inv_count[c] !== 8'd10) begin errors++; $display("FAIL t6_inv%0d got=%0d exp=10", c, dut.inv_count[c]); end
    end
    reset_n = 1'b1;
    $display("reset mid-request done");
  endtask

  task automatic test_refill();
    bit seen = 1'b0;
    @(negedge clk); bus_if.i_start = 1'b1; bus_if.i_amount = 31'd100;
    @(negedge clk); bus_if.i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.o_coin_req != '0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (bus_if.o_coin_req !== 3'b001) begin errors++; $display("FAIL t7_req got=%b exp=001 seen=%0b", bus_if.o_coin_req, seen); end
    bus_if.i_coin_ack = 1'b1; bus_if.i_refill = 3'b001;
    @(negedge clk);
    bus_if.i_coin_ack = 1'b0; bus_if.i_refill = 3'b000;
    checks++; if (dut.inv_count[0] !== 8'd10) begin errors++; $display("FAIL t7_same_cycle_inv0 got=%0d exp=10", dut.inv_count[0]); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.o_done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!seen || bus_if.o_remainder !== 31'd0) begin errors++; $display("FAIL t7_done rem=%0d done_seen=%0b exp rem=0 done_seen=1", bus_if.o_remainder, seen); end
    @(negedge clk); bus_if.i_refill = 3'b100;
    @(negedge clk); bus_if.i_refill = 3'b000;
    checks++; if (dut.inv_count[2] !== 8'd11) begin errors++; $display("FAIL t7_refill_inv2 got=%0d exp=11", dut.inv_count[2]); end
    bus_if.i_refill = 3'b010;
    repeat (300) @(negedge clk);
    bus_if.i_refill = 3'b000;
    @(negedge clk);
    checks++; if (dut.inv_count[1] !== 8'd255) begin errors++; $display("FAIL t7_saturate_inv1 got=%0d exp=255", dut.inv_count[1]); end
    $display("refill inv=%0d/%0d/%0d", dut.inv_count[0], dut.inv_count[1], dut.inv_count[2]);
  endtask

  initial begin
    test_reset();
    test_largest_first();
    test_zero_amount();
    test_no_big_coin();
    test_remainder();
    test_timeout();
    test_reset_mid_req();
    test_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
